// File: rtl/zjh_mux_scan.sv
// zjh_mux_scan: registered N-channel x W-bit data selector with a valid/ready
// output stage. Direct mode picks the channel from Sel; scan mode walks the
// channels round-robin, taking one sample every DWELL cycles. Enable is
// active-low and, when high, clears the output stage and the scan sequencer.
module zjh_mux_scan #(
    parameter int CH_NUM = 4,
    parameter int WIDTH  = 8,
    parameter int SEL_W  = 2,
    parameter int DWELL  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      Enable,
    input  logic                      Mode,
    input  logic [SEL_W-1:0]          Sel,
    input  logic [CH_NUM*WIDTH-1:0]   DateIn,
    output logic [WIDTH-1:0]          DateOut,
    output logic [SEL_W-1:0]          ChOut,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Dwell counter is at least one bit wide so DWELL=1 still elaborates.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CH_NUM - 1);

    typedef enum logic [1:0] {
        ST_DISABLED   = 2'd0,
        ST_DIRECT     = 2'd1,
        ST_SCAN_COUNT = 2'd2,
        ST_SCAN_STALL = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   data_q,      data_d;
    logic [SEL_W-1:0]   ch_q,        ch_d;
    logic               valid_q,     valid_d;
    logic [SEL_W-1:0]   scan_ch_q,   scan_ch_d;
    logic [CNT_W-1:0]   dwell_cnt_q, dwell_cnt_d;

    logic [WIDTH-1:0]   chan [CH_NUM];
    logic               free;
    logic [WIDTH-1:0]   sel_data;
    logic [WIDTH-1:0]   scan_data;
    logic [SEL_W-1:0]   scan_ch_next;

    // Unpack the flat input bus into one word per channel.
    always_comb begin
        for (int k = 0; k < CH_NUM; k++) begin
            chan[k] = DateIn[k*WIDTH +: WIDTH];
        end
    end

    // Channel lookup by compare rather than by index, so a Sel at or above
    // CH_NUM naturally yields zero data instead of an out-of-range read.
    always_comb begin
        sel_data  = '0;
        scan_data = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (Sel == SEL_W'(k)) begin
                sel_data = chan[k];
            end
            if (scan_ch_q == SEL_W'(k)) begin
                scan_data = chan[k];
            end
        end
    end

    // Round-robin successor of the current scan channel.
    always_comb begin
        scan_ch_next = (scan_ch_q == CH_LAST) ? '0 : scan_ch_q + 1'b1;
    end

    // Next-state and output-stage logic for the selector/sequencer FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // through this block leaves a variable unassigned and infers a latch.
        free        = !valid_q || out_ready;
        state_d     = state_q;
        data_d      = data_q;
        ch_d        = ch_q;
        // An accept without a capture empties the slot; captures override.
        valid_d     = valid_q && !out_ready;
        scan_ch_d   = scan_ch_q;
        dwell_cnt_d = dwell_cnt_q;

        if (Enable) begin
            // Disabled wins over everything; a pending sample is dropped.
            state_d     = ST_DISABLED;
            data_d      = '0;
            ch_d        = '0;
            valid_d     = 1'b0;
            scan_ch_d   = '0;
            dwell_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_DISABLED: begin
                    // Leaving disable only picks the mode; sampling starts
                    // from the following edge with a fresh sequencer.
                    state_d     = Mode ? ST_SCAN_COUNT : ST_DIRECT;
                    scan_ch_d   = '0;
                    dwell_cnt_d = '0;
                end

                ST_DIRECT: begin
                    if (Mode) begin
                        state_d     = ST_SCAN_COUNT;
                        scan_ch_d   = '0;
                        dwell_cnt_d = '0;
                    end else if (free) begin
                        data_d  = sel_data;
                        ch_d    = Sel;
                        valid_d = 1'b1;
                    end
                end

                ST_SCAN_COUNT: begin
                    if (!Mode) begin
                        state_d     = ST_DIRECT;
                        scan_ch_d   = '0;
                        dwell_cnt_d = '0;
                    end else if (dwell_cnt_q == CNT_LAST) begin
                        if (free) begin
                            data_d      = scan_data;
                            ch_d        = scan_ch_q;
                            valid_d     = 1'b1;
                            scan_ch_d   = scan_ch_next;
                            dwell_cnt_d = '0;
                        end else begin
                            // Sequencer freezes until the consumer frees the slot.
                            state_d = ST_SCAN_STALL;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end
                end

                ST_SCAN_STALL: begin
                    if (!Mode) begin
                        state_d     = ST_DIRECT;
                        scan_ch_d   = '0;
                        dwell_cnt_d = '0;
                    end else if (free) begin
                        // Sample the live input now, not the value from when
                        // the stall began.
                        data_d      = scan_data;
                        ch_d        = scan_ch_q;
                        valid_d     = 1'b1;
                        scan_ch_d   = scan_ch_next;
                        dwell_cnt_d = '0;
                        state_d     = ST_SCAN_COUNT;
                    end
                end

                default: begin
                    state_d = ST_DISABLED;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: flops take non-blocking assignments so every register samples
        // the pre-edge values of the others, independent of statement order.
        if (!rst_n) begin
            state_q     <= ST_DISABLED;
            data_q      <= '0;
            ch_q        <= '0;
            valid_q     <= 1'b0;
            scan_ch_q   <= '0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            ch_q        <= ch_d;
            valid_q     <= valid_d;
            scan_ch_q   <= scan_ch_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    assign DateOut   = data_q;
    assign ChOut     = ch_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_zjh_mux_scan.sv
// Directed bench for zjh_mux_scan (CH_NUM=4, WIDTH=8, DWELL=4). Expected
// samples are queued when the stimulus that produces them is driven and are
// compared when the consumer accepts them; state points are checked directly.
module tb_zjh_mux_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Enable;
    logic        Mode;
    logic [1:0]  Sel;
    logic [31:0] DateIn;
    logic [7:0]  DateOut;
    logic [1:0]  ChOut;
    logic        out_valid;
    logic        out_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [9:0]  sb [$];

    zjh_mux_scan #(
        .CH_NUM (4),
        .WIDTH  (8),
        .SEL_W  (2),
        .DWELL  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Enable    (Enable),
        .Mode      (Mode),
        .Sel       (Sel),
        .DateIn    (DateIn),
        .DateOut   (DateOut),
        .ChOut     (ChOut),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] slice(input logic [31:0] d, input int ch);
        return 8'(d >> (8 * ch));
    endfunction

    task automatic expect_sample(input int ch);
        sb.push_back({2'(ch), slice(DateIn, ch)});
    endtask

    // One clock: if a sample is about to be accepted, score it, then advance
    // to the next falling edge where outputs are stable.
    task automatic cyc();
        logic [9:0] e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            e = (sb.size() != 0) ? sb.pop_front() : 10'bx;
            check("accept", 32'({ChOut, DateOut}), 32'(e));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run until out_valid rises (bounded) and check the number of edges taken.
    task automatic wait_capture(input string tag, input int exp_gap);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (out_valid !== 1'b1 && n < 16);
        check(tag, 32'(n), 32'(exp_gap));
    endtask

    initial begin
        rst_n     = 1'b0;
        Enable    = 1'b0;
        Mode      = 1'b0;
        Sel       = 2'd0;
        out_ready = 1'b1;
        DateIn    = 32'h4433_2211;

        // 1. Reset held for two clocks.
        repeat (2) begin
            cyc();
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_data",  32'(DateOut),   32'd0);
            check("rst_ch",    32'(ChOut),     32'd0);
        end
        rst_n = 1'b1;
        cyc();
        check("rel_valid", 32'(out_valid), 32'd0);
        check("rel_data",  32'(DateOut),   32'd0);

        // 2. Direct mode, full throughput, one clock latency.
        for (int s = 0; s < 4; s++) begin
            Sel = 2'(s);
            expect_sample(s);
            cyc();
            check("dir_valid", 32'(out_valid), 32'd1);
            check("dir_ch",    32'(ChOut),     32'(s));
            check("dir_data",  32'(DateOut),   32'(slice(32'h4433_2211, s)));
        end

        // 3. Backpressure in direct mode: output holds, Sel ignored.
        Sel = 2'd2;
        expect_sample(2);
        cyc();
        out_ready = 1'b0;
        Sel       = 2'd1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data",  32'(DateOut),   32'h33);
            check("bp_ch",    32'(ChOut),     32'd2);
        end
        out_ready = 1'b1;
        expect_sample(1);
        cyc();
        check("bp_rel_data", 32'(DateOut), 32'h22);
        check("bp_rel_ch",   32'(ChOut),   32'd1);

        // 4. Scan mode: mode-change edge clears the sequencer, then one
        //    capture every DWELL edges, channels 0,1,2,3,0.
        Mode = 1'b1;
        cyc();
        check("mode_chg_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            DateIn = $urandom;
            expect_sample(k % 4);
            wait_capture("scan_gap", 4);
            check("scan_ch", 32'(ChOut), 32'(k % 4));
        end

        // 5. Stall with ch0 pending; sequencer freezes at ch1; new data on
        //    ch1 arrives during the stall and must be the one captured.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) DateIn[15:8] = 8'hA5;
            cyc();
        end
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_ch",    32'(ChOut),     32'd0);
        out_ready = 1'b1;
        expect_sample(1);
        cyc();
        check("unstall_data", 32'(DateOut), 32'hA5);
        check("unstall_ch",   32'(ChOut),   32'd1);
        DateIn = $urandom;
        expect_sample(2);
        wait_capture("post_stall_gap", 4);
        check("post_stall_ch", 32'(ChOut), 32'd2);

        // 6. Disable mid-stall: pending ch2 sample is dropped.
        out_ready = 1'b0;
        repeat (6) cyc();
        check("pre_dis_valid", 32'(out_valid), 32'd1);
        Enable = 1'b1;
        cyc();
        check("dis_valid", 32'(out_valid), 32'd0);
        check("dis_data",  32'(DateOut),   32'd0);
        check("dis_ch",    32'(ChOut),     32'd0);
        void'(sb.pop_front());
        // Re-enable in scan mode: one edge leaves DISABLED, then DWELL edges.
        Enable    = 1'b0;
        Mode      = 1'b1;
        out_ready = 1'b1;
        DateIn    = $urandom;
        expect_sample(0);
        wait_capture("restart_gap", 5);
        check("restart_ch", 32'(ChOut), 32'd0);
        cyc();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
